// File: rtl/mc_fanout.sv
// Multicast/unicast fan-out stage: looks up a command's member mask in group_table,
// then replicates the command to every member egress port and retires it once all copies are taken.
module mc_fanout #(
    parameter int NUM_PORTS     = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int GROUP_ID_BITS = 2,
    parameter int PORT_SEL_LSB  = 4,
    parameter int EXCLUDE_SRC   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]        cmd_data,
    input  logic [$clog2(NUM_PORTS)-1:0] cmd_src,
    output logic                         lkp_valid,
    output logic [ADDR_WIDTH-1:0]        lkp_addr,
    input  logic                         lkp_ready,
    input  logic                         res_valid,
    input  logic [NUM_PORTS-1:0]         res_member_mask,
    input  logic [GROUP_ID_BITS-1:0]     res_group_id,
    input  logic                         res_is_mc,
    output logic [NUM_PORTS-1:0]         out_valid,
    input  logic [NUM_PORTS-1:0]         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [GROUP_ID_BITS-1:0]     out_group_id,
    output logic                         out_is_mc,
    output logic                         done_pulse,
    output logic                         drop_pulse,
    output logic [15:0]                  fanout_count
);

    // state    | meaning
    // IDLE     | ready for a new command
    // LOOKUP   | presenting captured address to group_table
    // WAIT_RES | waiting for the lookup result
    // ISSUE    | driving copies to the ports still pending in the mask
    // DROP     | empty mask, retire without issuing copies

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_RES,
        S_ISSUE,
        S_DROP
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [PW-1:0]              src_q, src_d;
    logic [NUM_PORTS-1:0]       mask_q, mask_d;
    logic [GROUP_ID_BITS-1:0]   grp_q, grp_d;
    logic                       is_mc_q, is_mc_d;
    logic [15:0]                cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]       accepted;
    logic [NUM_PORTS-1:0]       remaining;
    logic [15:0]                acc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            src_q   <= '0;
            mask_q  <= '0;
            grp_q   <= '0;
            is_mc_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
            grp_q   <= grp_d;
            is_mc_q <= is_mc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        src_d      = src_q;
        mask_d     = mask_q;
        grp_d      = grp_q;
        is_mc_d    = is_mc_q;
        cnt_d      = cnt_q;
        accepted   = '0;
        remaining  = mask_q;
        acc_cnt    = '0;
        done_pulse = 1'b0;
        drop_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    src_d   = cmd_src;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lkp_ready) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    if (res_is_mc) begin
                        mask_d = res_member_mask;
                        if (EXCLUDE_SRC != 0) begin
                            mask_d[src_q] = 1'b0;
                        end
                        grp_d   = res_group_id;
                        is_mc_d = 1'b1;
                    end else begin
                        // Unicast: destination port comes from the address, lookup mask is irrelevant.
                        mask_d = '0;
                        mask_d[addr_q[PORT_SEL_LSB +: PW]] = 1'b1;
                        grp_d   = '0;
                        is_mc_d = 1'b0;
                    end
                    state_d = (mask_d != '0) ? S_ISSUE : S_DROP;
                end
            end
            S_ISSUE: begin
                accepted  = mask_q & out_ready;
                remaining = mask_q & ~out_ready;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    acc_cnt = acc_cnt + 16'(accepted[i]);
                end
                cnt_d  = cnt_q + acc_cnt;
                mask_d = remaining;
                if (remaining == '0) begin
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                done_pulse = 1'b1;
                drop_pulse = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign lkp_valid    = (state_q == S_LOOKUP);
    assign lkp_addr     = addr_q;
    assign out_valid    = (state_q == S_ISSUE) ? mask_q : '0;
    assign out_addr     = addr_q;
    assign out_data     = data_q;
    assign out_group_id = grp_q;
    assign out_is_mc    = is_mc_q;
    assign fanout_count = cnt_q;

endmodule
